// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 16x oversampled, LSB-first, one-cycle strobes for good bytes and stop-bit errors.
// Everything runs on sysclk; the 16x sample tick is a clock enable from an internal divider.
module uart_receiver #(
    parameter int DIV       = 326,
    parameter int DATA_BITS = 8
) (
    input  logic                 sysclk,
    input  logic                 resetb,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_status,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic [8:0] DIV_M1   = 9'(DIV - 1);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    // state     | meaning
    // IDLE      | line idle, watching for a low level on rxs
    // START     | counting to mid start bit to reject glitches
    // DATA      | sampling data bits at mid-bit
    // STOP      | sampling the stop bit
    // WAIT_IDLE | stop bit was low; hold until the line returns high
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               r_state;
    logic [1:0]           r_sync;
    logic [8:0]           r_div;
    logic [3:0]           r_sample_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_status;
    logic                 r_frame_err;
    logic                 r_busy;

    logic w_rxs;
    logic w_tick;
    logic w_start_det;

    assign w_rxs       = r_sync[1];
    assign w_tick      = (r_div == DIV_M1);
    assign w_start_det = (r_state == IDLE) && !w_rxs;

    always_ff @(posedge sysclk or negedge resetb) begin
        if (!resetb) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    // Cleared on start detection so every sample point is a fixed offset from the start edge.
    always_ff @(posedge sysclk or negedge resetb) begin
        if (!resetb) begin
            r_div <= '0;
        end else if (w_start_det || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 9'd1;
        end
    end

    always_ff @(posedge sysclk or negedge resetb) begin
        if (!resetb) begin
            r_state      <= IDLE;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_rx_data    <= '0;
            r_rx_status  <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rx_status <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_state      <= START;
                        r_sample_cnt <= '0;
                        r_busy       <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_sample_cnt == 4'd7) begin
                            r_sample_cnt <= '0;
                            if (w_rxs) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state   <= DATA;
                                r_bit_cnt <= '0;
                            end
                        end else begin
                            r_sample_cnt <= r_sample_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_sample_cnt <= r_sample_cnt + 4'd1;
                        if (r_sample_cnt == 4'd15) begin
                            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                            if (r_bit_cnt == LAST_BIT) begin
                                r_state <= STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_sample_cnt <= r_sample_cnt + 4'd1;
                        if (r_sample_cnt == 4'd15) begin
                            if (w_rxs) begin
                                r_rx_data   <= r_shift;
                                r_rx_status <= 1'b1;
                                r_state     <= IDLE;
                                r_busy      <= 1'b0;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= WAIT_IDLE;
                            end
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (w_rxs) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_status = r_rx_status;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 8N1 UART receiver: samples the serial `rx` line at 16x the bit rate and assembles bytes LSB-first.
- Presents each good byte on `rx_data` with a one-cycle `rx_status` strobe; flags stop-bit errors.
- Serves as the receive end of the serial link that the baud generator feeds.
- Fully synchronous to `sysclk`: the 16x sample tick is an internal enable, not a derived clock.

Parameters:
- DIV, 326, sysclk cycles per 16x sample tick (50 MHz / (9600*16) ≈ 326); legal range 2..511.
- DATA_BITS, 8, data bits per frame; fixed at 8 for this release.

Ports:
- sysclk  input  1  system clock; all logic on posedge.
- resetb  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idles high; asynchronous to sysclk.
- rx_data  output  8  last correctly framed byte; holds until the next good frame.
- rx_status  output  1  one-sysclk pulse: rx_data was just updated.
- frame_err  output  1  one-sysclk pulse: the stop bit sampled low.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (resetb low, async):
  - rx_data=8'h00; rx_status=0; frame_err=0; busy=0.
  - FSM=IDLE; synchronizer flops=1; tick divider=0; sample counter=0; bit counter=0; shift register=0.
- Synchronizer:
  - 2-flop on rx; `rxs` is the second stage. All decisions use rxs only.
- Tick divider:
  - 9-bit counter 0..DIV-1; `tick` is high for one cycle when counter==DIV-1, then the counter wraps to 0.
  - Forced to 0 on the cycle start is detected, so tick spacing from the start edge is deterministic.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - rxs==0 -> START; sample_cnt=0; divider cleared.
- START, on each tick, sample_cnt increments:
  - At the tick where sample_cnt==7 (mid start bit):
    - rxs==1 -> glitch, return to IDLE, no outputs.
    - rxs==0 -> DATA; sample_cnt=0; bit_cnt=0.
- DATA, on each tick, sample_cnt increments mod 16:
  - At sample_cnt==15: shift rxs into the MSB of the shift register (shift right), so the first bit lands in bit 0 after 8 shifts; bit_cnt++.
  - After the 8th bit -> STOP; sample_cnt=0.
- STOP, at the tick where sample_cnt==15:
  - rxs==1 -> rx_data<=shift; rx_status=1 for the next cycle only -> IDLE.
  - rxs==0 -> frame_err=1 for one cycle; rx_data unchanged -> WAIT_IDLE.
- WAIT_IDLE:
  - Stays until rxs==1, then -> IDLE. A held-low line (break) produces exactly one frame_err, never repeated frames.
- Timing:
  - Data and stop samples fall at mid-bit, 16*DIV sysclk cycles apart.
  - rx_status asserts (8+16*9)*DIV + ~3 sysclk cycles after the falling rx edge (2 sync + detect).
- Status signals:
  - rx_status and frame_err are never both high.
  - busy=0 only in IDLE.
- Back-to-back frames:
  - A start bit beginning immediately after the stop-bit sample is accepted, because IDLE is re-entered at mid-stop.
- Reset mid-frame:
  - All state returns to reset values at once; the partial byte is discarded and no strobe is issued.
- rx changes between ticks are ignored except for start detection in IDLE.

Test Plan (DIV=4, bit time=64 cycles):
- Reset with rx=1, hold 200 cycles -> rx_data=0x00; rx_status, frame_err, busy all 0.
- Send 0x55, 8N1 -> exactly one rx_status pulse; rx_data=0x55; busy falls with the pulse; frame_err never high.
- Send 0xA3 then 0x0F back-to-back (no idle gap) -> two rx_status pulses 640 cycles apart; rx_data=0xA3 then 0x0F.
- Low glitch on rx of 20 cycles (shorter than a half bit) -> FSM returns to IDLE; no rx_status, no frame_err; rx_data unchanged.
- Frame 0x81 with stop bit driven 0, then rx held 0 for 2000 cycles -> one frame_err pulse; rx_data keeps the prior value; busy stays 1 until rx returns to 1.
- Assert resetb during bit 4 of 0xC6, release, then send 0x3C -> no strobe for 0xC6; rx_data=0x3C after the next frame.
